// File: rtl/fetch_pkg.sv
// Shared widths, dispatch record and output-stage state encoding for the fetch EXEC init path.
package fetch_pkg;

  localparam int WF_ID_W_DFLT = 6;
  localparam int EXEC_MASK_W  = 64;
  localparam int LANE_IDX_W   = 6;

  typedef logic [LANE_IDX_W-1:0]  lane_idx_t;
  typedef logic [EXEC_MASK_W-1:0] exec_mask_t;

  typedef struct packed {
    logic [WF_ID_W_DFLT-1:0] wf_id;
    lane_idx_t               size_m1;
  } disp_rec_t;

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

endpackage

// File: rtl/mask_gen.sv
// Thermometer mask: size_m1_i = N drives bits [N:0] high. Purely combinational.
module mask_gen
  import fetch_pkg::*;
(
  input  lane_idx_t  size_m1_i,
  output exec_mask_t mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < EXEC_MASK_W; i++) begin
      mask_o[i] = (i <= int'(size_m1_i));
    end
  end

endmodule

// File: rtl/fetch_exec_init.sv
// Dispatch record FIFO feeding a registered EXEC-table init write; FETCH_EXEC_INIT_STALL_CNT_EN adds stall_cnt.
// Accept-to-valid latency 2 edges, 1 record/cycle; output held until exec_wr_ready, in_ready low when full or flushing.
module fetch_exec_init
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WF_ID_W = WF_ID_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WF_ID_W-1:0] in_wf_id,
  input  logic [5:0]         in_size_m1,
  output logic               exec_wr_valid,
  input  logic               exec_wr_ready,
  output logic [WF_ID_W-1:0] exec_wr_wfid,
  output logic [63:0]        exec_wr_mask,
  output logic               busy
`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WF_ID_W-1:0] wf_id;
    lane_idx_t          size_m1;
  } rec_t;

  rec_t               fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:0]         state_q, state_d;
  logic [WF_ID_W-1:0] wfid_q, wfid_d;
  exec_mask_t         mask_q, mask_d;

  rec_t       head;
  exec_mask_t head_mask;
  logic       fifo_nempty;
  logic       push;
  logic       pop;

  assign head        = fifo_q[rd_ptr_q];
  assign fifo_nempty = (cnt_q != '0);
  assign in_ready    = (cnt_q < CNT_W'(DEPTH)) && !flush;
  assign push        = in_valid && in_ready;
  // Pop whenever the output register is free or being drained this edge.
  assign pop         = fifo_nempty && !flush &&
                       ((state_q == OUT_EMPTY) || exec_wr_ready);

  mask_gen u_mask_gen (
    .size_m1_i (head.size_m1),
    .mask_o    (head_mask)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    wfid_d   = wfid_q;
    mask_d   = mask_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      state_d  = OUT_EMPTY;
      wfid_d   = '0;
      mask_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        state_d = OUT_FULL;
        wfid_d  = head.wf_id;
        mask_d  = head_mask;
      end else if ((state_q == OUT_FULL) && exec_wr_ready) begin
        state_d = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= OUT_EMPTY;
      wfid_q   <= '0;
      mask_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      wfid_q   <= wfid_d;
      mask_q   <= mask_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{wf_id: in_wf_id, size_m1: in_size_m1};
  end

  assign exec_wr_valid = (state_q == OUT_FULL);
  assign exec_wr_wfid  = wfid_q;
  assign exec_wr_mask  = mask_q;
  assign busy          = fifo_nempty || exec_wr_valid;

`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (exec_wr_valid && !exec_wr_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Cleared by reset only so abort storms remain visible after a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_exec_init.sv
// Scoreboard bench for fetch_exec_init: driver queues expected writes, negedge monitor pops and compares.
module tb_fetch_exec_init;

  localparam int WW = 6;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_wf_id;
  logic [5:0]    in_size_m1;
  logic          exec_wr_valid;
  logic          exec_wr_ready;
  logic [WW-1:0] exec_wr_wfid;
  logic [63:0]   exec_wr_mask;
  logic          busy;
`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  fetch_exec_init #(.DEPTH(4), .WF_ID_W(WW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wf_id      (in_wf_id),
    .in_size_m1    (in_size_m1),
    .exec_wr_valid (exec_wr_valid),
    .exec_wr_ready (exec_wr_ready),
    .exec_wr_wfid  (exec_wr_wfid),
    .exec_wr_mask  (exec_wr_mask),
    .busy          (busy)
`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] wfid;
    logic [63:0]   mask;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  bit   rand_rdy = 1'b0;

  logic [WW-1:0] t3_wf [5] = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
  logic [5:0]    t3_sz [5] = '{6'd0, 6'd31, 6'd62, 6'd63, 6'd7};
  logic [63:0]   t3_m  [5] = '{64'h0000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0000_0000_0000_00FF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_mask(input logic [5:0] sz);
    logic [6:0] n;
    n = {1'b0, sz} + 7'd1;
    if (n == 7'd64) return {64{1'b1}};
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) exec_wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic try_push(input logic [WW-1:0] wf, input logic [5:0] sz,
                          input logic [63:0] m, output bit acc);
    in_valid   = 1'b1;
    in_wf_id   = wf;
    in_size_m1 = sz;
    @(negedge clk);
    acc = in_ready;
    if (acc) sb.push_back(exp_t'{wfid: wf, mask: m});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [WW-1:0] wf, input logic [5:0] sz);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 100) begin
      try_push(wf, sz, model_mask(sz), acc);
      k++;
    end
    chk("push_accept_timeout", acc, 1);
  endtask

  task automatic drain();
    exec_wr_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) break;
      tick();
    end
    chk("drain_busy", busy, 0);
    chk("drain_sb_empty", sb.size(), 0);
    tick();
  endtask

  // Monitor: every handshake pops one expectation; stalled outputs must hold.
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_wfid;
  logic [63:0]   prev_mask;
  exp_t          mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", exec_wr_valid, 1);
          chk("hold_wfid", exec_wr_wfid, prev_wfid);
          chk("hold_mask", exec_wr_mask, prev_mask);
        end
        if (exec_wr_valid) chk("mask_nonzero", exec_wr_mask != 64'd0, 1);
        if (exec_wr_valid && exec_wr_ready && !flush) begin
          n_writes++;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got wfid %h mask %h, expected no write",
                     exec_wr_wfid, exec_wr_mask);
          end else begin
            mon_e = sb.pop_front();
            chk("sb_wfid", exec_wr_wfid, mon_e.wfid);
            chk("sb_mask", exec_wr_mask, mon_e.mask);
          end
        end
        prev_stall = exec_wr_valid && !exec_wr_ready && !flush;
        prev_wfid  = exec_wr_wfid;
        prev_mask  = exec_wr_mask;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int w0;
    logic [WW-1:0] wf;
    logic [5:0]    sz;

    rst           = 1'b1;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_wf_id      = '0;
    in_size_m1    = '0;
    exec_wr_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", exec_wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mask", exec_wr_mask, 64'd0);
    chk("rst_wfid", exec_wr_wfid, 0);
`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Reset mid-burst: one record in the output stage, three queued.
    for (int i = 0; i < 4; i++) begin
      try_push(WW'(i + 1), 6'(i), model_mask(6'(i)), acc);
      chk("t1_push_acc", acc, 1);
    end
    chk("t1_busy", busy, 1);
    chk("t1_valid", exec_wr_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", exec_wr_valid, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_mask", exec_wr_mask, 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy_after", busy, 0);
    tick();

    // Single record, exact timing.
    exec_wr_ready = 1'b1;
    try_push(6'd5, 6'd15, 64'h0000_0000_0000_FFFF, acc);
    chk("t2_acc", acc, 1);
    @(negedge clk);
    chk("t2_valid_early", exec_wr_valid, 0);
    tick();
    @(negedge clk);
    chk("t2_valid", exec_wr_valid, 1);
    chk("t2_wfid", exec_wr_wfid, 6'd5);
    chk("t2_mask", exec_wr_mask, 64'h0000_0000_0000_FFFF);
    tick();
    @(negedge clk);
    chk("t2_valid_gone", exec_wr_valid, 0);
    tick();

    // Back-pressure until full, then release at one write per cycle.
    exec_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      try_push(t3_wf[i], t3_sz[i], t3_m[i], acc);
      chk("t3_push_acc", acc, 1);
    end
    @(negedge clk);
    chk("t3_in_ready_full", in_ready, 0);
    try_push(6'd15, 6'd1, 64'h3, acc);
    chk("t3_push_full_rejected", acc, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t3_held_mask", exec_wr_mask, 64'h1);
    chk("t3_held_wfid", exec_wr_wfid, 6'd10);
    tick();
    exec_wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_burst_valid", exec_wr_valid, 1);
      chk("t3_burst_mask", exec_wr_mask, t3_m[i]);
      tick();
    end
    @(negedge clk);
    chk("t3_burst_end", exec_wr_valid, 0);
    tick();

    // Flush beats simultaneous push and write handshake.
    exec_wr_ready = 1'b0;
    try_push(6'd9, 6'd3, 64'hF, acc);
    tick();
    @(negedge clk);
    chk("t4_pre_valid", exec_wr_valid, 1);
    tick();
    flush         = 1'b1;
    in_valid      = 1'b1;
    in_wf_id      = 6'd10;
    in_size_m1    = 6'd5;
    exec_wr_ready = 1'b1;
    w0            = n_writes;
    @(negedge clk);
    chk("t4_in_ready_flush", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t4_valid_after", exec_wr_valid, 0);
    chk("t4_busy_after", busy, 0);
    repeat (5) tick();
    chk("t4_no_write", n_writes - w0, 0);

    // Random stream with random back-pressure.
    w0       = n_writes;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wf = WW'($urandom_range(0, 63));
      sz = 6'($urandom_range(0, 63));
      push_wait(wf, sz);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    drain();
    chk("t5_write_count", n_writes - w0, 100);

`ifdef FETCH_EXEC_INIT_STALL_CNT_EN
    // Stall counter saturation, flush persistence, reset clear.
    exec_wr_ready = 1'b0;
    try_push(6'd20, 6'd8, 64'h1FF, acc);
    tick();
    @(negedge clk);
    chk("t6_stall_start", stall_cnt, 0);
    repeat (10) tick();
    @(negedge clk);
    chk("t6_stall_10", stall_cnt, 10);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("t6_stall_sat", stall_cnt, 16'hFFFF);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_flush_keeps", stall_cnt, 16'hFFFF);
    chk("t6_flush_valid", exec_wr_valid, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_clears", stall_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
